// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
// Imported by the arbiter top and its round-robin picker.
package regfile_write_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_MAX  = 4;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot-or-zero grant vector.
module rr_pick
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates N write requesters onto one register-file write port,
// with round-robin fairness and bounded burst locking.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          hold,
  output logic                          wr_enable,
  output logic [ADDR_WIDTH-1:0]         wr_address,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [PW-1:0]                 grant_id
);

  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BW-1:0]   cnt_inc;
  logic            wr_enable_q, wr_enable_d;
  logic [ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [PW-1:0]   grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               locked_live;
  logic               xfer;
  logic [PW-1:0]      gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // rr_ptr always sits at owner+1 while locked, so one picker serves both
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    locked_live = (state_q == LOCKED) && req_valid[owner_q];
    req_ready   = '0;
    if (rst_n && !hold) begin
      if (locked_live) req_ready[owner_q] = 1'b1;
      else             req_ready = arb_gnt;
    end
    xfer    = |(req_valid & req_ready);
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) gnt_idx = PW'(i);
    end
    sel_addr = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    cnt_inc  = burst_cnt_q + 1'b1;

    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (!hold) begin
      if (locked_live) begin
        rr_ptr_d = wrap_inc(owner_q);
        if (!req_lock[owner_q] || int'(cnt_inc) >= BURST_MAX) begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_inc;
        end
      end else begin
        state_d     = ARB;
        burst_cnt_d = '0;
        if (xfer) begin
          rr_ptr_d = wrap_inc(gnt_idx);
          if (req_lock[gnt_idx] && BURST_MAX > 1) begin
            state_d     = LOCKED;
            owner_d     = gnt_idx;
            burst_cnt_d = BW'(1);
          end
        end
      end
    end

    wr_enable_d  = xfer && (sel_addr != '0);
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    grant_id_d   = grant_id_q;
    if (xfer) begin
      wr_address_d = sel_addr;
      wr_data_d    = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      grant_id_d   = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      wr_enable_q  <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      wr_enable_q  <= wr_enable_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign wr_enable  = wr_enable_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table
// plus hand sequences for zero-register write and reset mid-burst.
module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_lock;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         hold;
  logic         wr_enable;
  logic [4:0]   wr_address;
  logic [31:0]  wr_data;
  logic [1:0]   grant_id;

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .hold       (hold),
    .wr_enable  (wr_enable),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] lock;
    logic       hold;
    logic [3:0] rdy;
    logic       wen;
    logic [4:0] addr;
    logic [1:0] gid;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l,
                     input logic h, input logic [3:0] r,
                     input logic we, input logic [4:0] a,
                     input logic [1:0] g);
    vec_t t;
    t.valid = v; t.lock = l; t.hold = h;
    t.rdy = r; t.wen = we; t.addr = a; t.gid = g;
    vq.push_back(t);
  endtask

  initial begin
    // fairness
    add(4'b1111, 4'b0000, 0, 4'b0001, 1, 5'd1, 2'd0);
    add(4'b1111, 4'b0000, 0, 4'b0010, 1, 5'd2, 2'd1);
    add(4'b1111, 4'b0000, 0, 4'b0100, 1, 5'd3, 2'd2);
    add(4'b1111, 4'b0000, 0, 4'b1000, 1, 5'd4, 2'd3);
    add(4'b1111, 4'b0000, 0, 4'b0001, 1, 5'd1, 2'd0);
    // burst: four grants to 2, then 0
    add(4'b0101, 4'b0100, 0, 4'b0100, 1, 5'd3, 2'd2);
    add(4'b0101, 4'b0100, 0, 4'b0100, 1, 5'd3, 2'd2);
    add(4'b0101, 4'b0100, 0, 4'b0100, 1, 5'd3, 2'd2);
    add(4'b0101, 4'b0100, 0, 4'b0100, 1, 5'd3, 2'd2);
    add(4'b0101, 4'b0100, 0, 4'b0001, 1, 5'd1, 2'd0);
    add(4'b1000, 4'b0000, 0, 4'b1000, 1, 5'd4, 2'd3);
    // hold three cycles, then grant 0
    add(4'b0011, 4'b0000, 1, 4'b0000, 0, 5'd4, 2'd3);
    add(4'b0011, 4'b0000, 1, 4'b0000, 0, 5'd4, 2'd3);
    add(4'b0011, 4'b0000, 1, 4'b0000, 0, 5'd4, 2'd3);
    add(4'b0011, 4'b0000, 0, 4'b0001, 1, 5'd1, 2'd0);
    // owner 1 drops valid after two grants
    add(4'b1010, 4'b0010, 0, 4'b0010, 1, 5'd2, 2'd1);
    add(4'b1010, 4'b0010, 0, 4'b0010, 1, 5'd2, 2'd1);
    add(4'b1000, 4'b0000, 0, 4'b1000, 1, 5'd4, 2'd3);
    add(4'b1011, 4'b0000, 0, 4'b0001, 1, 5'd1, 2'd0);

    for (int i = 0; i < 4; i++) begin
      req_addr[i*5 +: 5]   = 5'(i + 1);
      req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    rst_n = 1'b0; hold = 1'b0;
    req_valid = 4'b1111; req_lock = 4'b0000;
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wen", 32'(wr_enable), 32'h0);
    chk("rst_addr", 32'(wr_address), 32'h0);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      req_valid = vq[i].valid;
      req_lock  = vq[i].lock;
      hold      = vq[i].hold;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vq[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wen", i), 32'(wr_enable), 32'(vq[i].wen));
      chk($sformatf("v%0d_addr", i), 32'(wr_address), 32'(vq[i].addr));
      chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vq[i].gid));
      chk($sformatf("v%0d_data", i), wr_data,
          32'hA000_0000 + 32'(vq[i].gid));
    end

    // zero register: accepted but no write strobe
    req_addr[5 +: 5]   = 5'd0;
    req_data[32 +: 32] = 32'hDEAD_BEEF;
    req_valid = 4'b0010; req_lock = 4'b0000; hold = 1'b0;
    @(negedge clk);
    chk("zero_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    chk("zero_wen", 32'(wr_enable), 32'h0);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    chk("idle_wen", 32'(wr_enable), 32'h0);

    // reset during a locked burst with a write in flight
    req_addr[5 +: 5] = 5'd2;
    req_valid = 4'b0100; req_lock = 4'b0100;
    @(negedge clk);
    chk("mb_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    chk("mb_wen", 32'(wr_enable), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mb_rst_wen", 32'(wr_enable), 32'h0);
    chk("mb_rst_ready", 32'(req_ready), 32'h0);
    chk("mb_rst_addr", 32'(wr_address), 32'h0);
    chk("mb_rst_gid", 32'(grant_id), 32'h0);
    req_valid = 4'b0101; req_lock = 4'b0000;
    @(negedge clk);
    chk("mb_low_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mb_rel_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("mb_rel_wen", 32'(wr_enable), 32'h1);
    chk("mb_rel_addr", 32'(wr_address), 32'h1);
    chk("mb_rel_gid", 32'(grant_id), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
